// File: rtl/column_readout_if.sv
// Controller-facing read port of the column readout block: request, column-half
// select and the VALID/READY word return path.
interface column_readout_if;
   logic        req;
   logic        adr;
   logic        ready;
   logic        busy;
   logic        valid;
   logic [15:0] dout;

   modport master (output req, adr, ready, input busy, valid, dout);
   modport slave  (input req, adr, ready, output busy, valid, dout);
endinterface

// File: rtl/column_readout.sv
// Sequences one precharge/sense read of the 32-bitline array and returns the
// selected 16-bit half over a VALID/READY handshake.
module column_readout #(
   parameter int PRECHARGE_CYCLES = 1,
   parameter int SENSE_CYCLES     = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   column_readout_if.slave bus,
   input  logic [31:0]     bls,
   output logic            pre,
   output logic            sae
);
   if (PRECHARGE_CYCLES < 1 || PRECHARGE_CYCLES > 15) begin : g_bad_pre
      $error("column_readout: PRECHARGE_CYCLES must be in 1..15");
   end
   if (SENSE_CYCLES < 1 || SENSE_CYCLES > 15) begin : g_bad_sense
      $error("column_readout: SENSE_CYCLES must be in 1..15");
   end

   // Counters are loaded with N-1 so a phase lasts exactly N cycles.
   localparam logic [3:0] PRE_LOAD   = 4'(PRECHARGE_CYCLES - 1);
   localparam logic [3:0] SENSE_LOAD = 4'(SENSE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PRECH, SENSE, HOLD} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        adr_reg, adr_next;
   logic [15:0] dout_reg, dout_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         adr_reg   <= 1'b0;
         dout_reg  <= 16'h0000;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         adr_reg   <= adr_next;
         dout_reg  <= dout_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      adr_next   = adr_reg;
      dout_next  = dout_reg;
      case (state_reg)
         IDLE: begin
            if (bus.req) begin
               adr_next   = bus.adr;
               cnt_next   = PRE_LOAD;
               state_next = PRECH;
            end
         end
         PRECH: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               cnt_next   = SENSE_LOAD;
               state_next = SENSE;
            end
         end
         SENSE: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               // Bitlines are sampled only on the final sense edge.
               dout_next  = adr_reg ? bls[31:16] : bls[15:0];
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (bus.ready) begin
               if (bus.req) begin
                  adr_next   = bus.adr;
                  cnt_next   = PRE_LOAD;
                  state_next = PRECH;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Every output is a decode of registered state, so no input reaches an output combinationally.
   assign pre       = (state_reg == PRECH);
   assign sae       = (state_reg == SENSE);
   assign bus.busy  = (state_reg != IDLE);
   assign bus.valid = (state_reg == HOLD);
   assign bus.dout  = dout_reg;
endmodule

// File: tb/tb_column_readout.sv
// Self-checking bench: two readout instances (default and 3/4 timing) driven by
// directed and random reads, checked cycle by cycle against a phase-count model.
module tb_column_readout;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] bls   = 32'h0;
   logic        pre0, sae0, pre1, sae1;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] last_dout [2];

   column_readout_if if0 ();
   column_readout_if if1 ();

   column_readout u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0), .bls(bls), .pre(pre0), .sae(sae0)
   );
   column_readout #(.PRECHARGE_CYCLES(3), .SENSE_CYCLES(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1), .bls(bls), .pre(pre1), .sae(sae1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic r, input logic a, input logic rd);
      if (k == 0) begin
         if0.req = r; if0.adr = a; if0.ready = rd;
      end else begin
         if1.req = r; if1.adr = a; if1.ready = rd;
      end
   endtask

   task automatic check_outs(input int k, input string tag, input logic p, input logic s,
                             input logic b, input logic v, input logic [15:0] d);
      logic op, os, ob, ov;
      logic [15:0] od;
      op = (k == 0) ? pre0 : pre1;
      os = (k == 0) ? sae0 : sae1;
      ob = (k == 0) ? if0.busy : if1.busy;
      ov = (k == 0) ? if0.valid : if1.valid;
      od = (k == 0) ? if0.dout : if1.dout;
      check($sformatf("%s%0d.pre", tag, k), 32'(op), 32'(p));
      check($sformatf("%s%0d.sae", tag, k), 32'(os), 32'(s));
      check($sformatf("%s%0d.busy", tag, k), 32'(ob), 32'(b));
      check($sformatf("%s%0d.valid", tag, k), 32'(ov), 32'(v));
      check($sformatf("%s%0d.dout", tag, k), 32'(od), 32'(d));
   endtask

   // REQ is presented for exactly one edge; returns #1 after that edge.
   task automatic issue_req(input int k, input logic a);
      drive(k, 1'b1, a, 1'($urandom % 2));
      @(posedge clk); #1;
      drive(k, 1'b0, 1'b0, 1'b0);
   endtask

   // Model of one read after its REQ edge: P precharge cycles, S sense cycles,
   // then HOLD for 'hold' cycles before the accepting edge.
   task automatic do_read(input int k, input int p, input int s, input logic a,
                          input logic fixed, input logic [31:0] fbls, input int hold,
                          input logic nreq, input logic nadr);
      logic [31:0] v;
      logic [15:0] exp;
      v = 32'h0;
      for (int i = 0; i < p; i++) begin
         check_outs(k, "prech", 1'b1, 1'b0, 1'b1, 1'b0, last_dout[k]);
         drive(k, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
         bls = fixed ? fbls : $urandom;
         @(posedge clk); #1;
      end
      for (int i = 0; i < s; i++) begin
         check_outs(k, "sense", 1'b0, 1'b1, 1'b1, 1'b0, last_dout[k]);
         drive(k, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
         v = fixed ? fbls : $urandom;
         bls = v;
         @(posedge clk); #1;
      end
      exp = a ? v[31:16] : v[15:0];
      last_dout[k] = exp;
      drive(k, 1'b0, 1'($urandom % 2), 1'b0);
      for (int i = 0; i < hold; i++) begin
         check_outs(k, "hold", 1'b0, 1'b0, 1'b1, 1'b1, exp);
         bls = $urandom;
         @(posedge clk); #1;
      end
      check_outs(k, "hold", 1'b0, 1'b0, 1'b1, 1'b1, exp);
      drive(k, nreq, nadr, 1'b1);
      @(posedge clk); #1;
      drive(k, 1'b0, 1'b0, 1'b0);
      if (!nreq) check_outs(k, "idle", 1'b0, 1'b0, 1'b0, 1'b0, exp);
   endtask

   initial begin : main
      int   k, p, s, n;
      logic a, na;
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      last_dout[0] = 16'h0;
      last_dout[1] = 16'h0;

      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check_outs(0, "rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
         check_outs(1, "rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
         @(posedge clk); #1;
      end

      // Default timing, low half, accepted at once.
      issue_req(0, 1'b0);
      do_read(0, 1, 2, 1'b0, 1'b1, 32'hA5A5_3C3C, 0, 1'b0, 1'b0);
      // High half, consumer stalls 10 cycles.
      issue_req(0, 1'b1);
      do_read(0, 1, 2, 1'b1, 1'b1, 32'hA5A5_3C3C, 10, 1'b0, 1'b0);
      // Back-to-back read straight out of HOLD.
      issue_req(0, 1'b1);
      do_read(0, 1, 2, 1'b1, 1'b1, 32'hA5A5_3C3C, 2, 1'b1, 1'b0);
      do_read(0, 1, 2, 1'b0, 1'b1, 32'h0000_FFFF, 0, 1'b0, 1'b0);
      // Longer timing instance with REQ/ADR noise during the read.
      issue_req(1, 1'b1);
      do_read(1, 3, 4, 1'b1, 1'b1, 32'h1234_5678, 1, 1'b0, 1'b0);

      for (int t = 0; t < 24; t++) begin
         k = t % 2;
         p = (k == 1) ? 3 : 1;
         s = (k == 1) ? 4 : 2;
         a = 1'($urandom % 2);
         n = $urandom_range(1, 3);
         issue_req(k, a);
         for (int j = 0; j < n; j++) begin
            na = 1'($urandom % 2);
            do_read(k, p, s, a, 1'b0, 32'h0, $urandom_range(0, 4), (j < n - 1), na);
            a = na;
         end
      end

      // Asynchronous reset in the middle of SENSE.
      issue_req(1, 1'b0);
      repeat (4) @(posedge clk);
      #3;
      check("rst_mid.sae_before", 32'(sae1), 32'd1);
      rst_n = 1'b0;
      #1;
      last_dout[0] = 16'h0;
      last_dout[1] = 16'h0;
      check_outs(0, "rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check_outs(1, "rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         check_outs(1, "post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
         @(posedge clk); #1;
      end
      issue_req(1, 1'b1);
      do_read(1, 3, 4, 1'b1, 1'b0, 32'h0, 1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/column_readout.md
Name: column_readout

Overview:
- Read-side counterpart to the column decoder: sequences one column read of the 32-bitline array and folds it back to a 16-bit word.
- Drives precharge and sense-amp enables, captures the 32 sensed bitlines, and selects the half given by ADR: ADR=0 selects bitlines 15..0, ADR=1 selects 31..16.
- Returns the word over a VALID/READY handshake to the array controller.

Parameters:
- PRECHARGE_CYCLES, 1, cycles PRE stays high per read; legal range 1..15.
- SENSE_CYCLES, 2, cycles SAE stays high per read; legal range 1..15.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  1  read request, sampled only in IDLE, or in HOLD on the handshake edge.
- ADR  in  1  column half select, captured together with REQ.
- BLS  in  32  sensed bitline values from the array, valid while SAE=1.
- PRE  out  1  bitline precharge enable.
- SAE  out  1  sense-amp enable.
- BUSY  out  1  high in every state except IDLE.
- DOUT  out  16  read word.
- VALID  out  1  DOUT holds a read result not yet accepted.
- READY  in  1  consumer accepts DOUT when VALID=1.

Behaviour:
- Reset (RST_N=0):
  - Takes effect immediately, asynchronously.
  - State=IDLE; PRE, SAE, BUSY, VALID = 0; DOUT = 16'h0000; captured address = 0; counter = 0.
  - Reset mid-read aborts the read with no output; first REQ after reset release starts a fresh read.
- All outputs are registered, or decoded purely from registered state; no combinational path from inputs to outputs.
- FSM states: IDLE, PRECH, SENSE, HOLD.
- IDLE:
  - REQ=1 on an edge: capture ADR, load counter with PRECHARGE_CYCLES-1, go to PRECH.
  - REQ=0: stay in IDLE.
- PRECH:
  - PRE=1.
  - Counter not 0: decrement.
  - Counter = 0: load counter with SENSE_CYCLES-1, go to SENSE.
- SENSE:
  - SAE=1.
  - Counter not 0: decrement.
  - Counter = 0: DOUT <= the captured-ADR half of BLS, VALID <= 1, go to HOLD.
  - BLS is sampled only on the final SENSE edge.
- HOLD:
  - VALID=1; DOUT stable.
  - Edge with READY=1 and REQ=1: VALID stays 1 for that edge only, then clears. Capture the new ADR and go to PRECH (back-to-back read, no IDLE cycle).
  - Edge with READY=1 and REQ=0: VALID <= 0, go to IDLE.
  - READY=0: stay in HOLD indefinitely.
- After a handshake, DOUT keeps its last value until the next capture.
- Latency: REQ sampled at edge E.
  - PRE=1 for edges E..E+P-1 intervals.
  - SAE=1 for the next S cycles.
  - VALID rises after edge E+P+S.
  - Defaults: VALID is high 3 cycles after the REQ edge.
- Back-to-back read from HOLD: the first PRE cycle directly follows the handshake cycle; throughput is one word per P+S+1 cycles.
- Ignored inputs:
  - REQ and ADR changes in PRECH and SENSE are ignored; requests are not queued.
  - READY outside HOLD is ignored.
- PRE and SAE are never high in the same cycle; they must also never be high in IDLE or HOLD.
- Counter width is 4 bits; parameters outside 1..15 are illegal and caught by an elaboration-time check.

Test Plan:
- Reset, then idle 5 cycles → PRE=SAE=BUSY=VALID=0, DOUT=16'h0000 throughout.
- Defaults; BLS=32'hA5A5_3C3C; REQ=1, ADR=0 for one edge; READY=1:
  - PRE high 1 cycle, then SAE high 2 cycles.
  - VALID high 3 cycles after the REQ edge with DOUT=16'h3C3C.
  - Then IDLE, BUSY=0.
- Same BLS, ADR=1, READY held 0 for 10 cycles → DOUT=16'hA5A5, VALID stays 1 and DOUT stays stable; READY=1 for one edge → VALID=0.
- Back-to-back: in HOLD, assert READY=1, REQ=1, ADR=0 with BLS changed to 32'h0000_FFFF → PRE rises the very next cycle, next VALID shows DOUT=16'hFFFF, BUSY never drops.
- PRECHARGE_CYCLES=3, SENSE_CYCLES=4:
  - PRE high exactly 3 cycles, then SAE exactly 4, VALID after 7 edges.
  - REQ toggling during PRECH and SENSE has no effect.
  - PRE&SAE never both 1.
- Drop RST_N during SENSE → all outputs 0 immediately; after release, no VALID without a new REQ.
